// File: rtl/idli_ex_serial_m.sv
// rtl/idli_ex_serial_m.sv - LSB-first lane-serial execution engine for the idli core
//
// Runs one WORD_W-bit operation as BEATS lane-wide beats, one beat per
// unstalled cycle, and accepts the next operation on the final beat so
// ops can issue back-to-back with no gap.
//
// Ports:
//   i_ex_gck            gated core clock
//   i_ex_rst_n          asynchronous active-low reset
//   i_ex_op_vld         decoded op valid
//   o_ex_op_acp         op accepted when high together with i_ex_op_vld
//   i_ex_op_fn          0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 EQ, 6 LTU, 7 LT
//   i_ex_op_wr_pc       op redirects the PC
//   i_ex_op_wr_q        op writes the predicate (compare fns only)
//   i_ex_pred_true      guarding predicate of the incoming op
//   i_ex_stall          freeze the current beat
//   i_ex_lhs/i_ex_rhs   operand lanes for the current beat
//   o_ex_res            result lane for the current beat
//   o_ex_res_vld        result lane is to be written to the register file
//   o_ex_beat           current beat index
//   o_ex_busy           op in flight
//   o_ex_pred_wr_en     predicate write strobe
//   o_ex_pred_wr_data   compare result
//   o_ex_redirect       in-flight op redirects the PC
//   o_ex_done           final beat completing this cycle

module idli_ex_serial_m #(
  parameter  int WORD_W = 16,
  parameter  int LANE_W = 4,
  localparam int BEATS  = WORD_W / LANE_W,
  localparam int CTR_W  = $clog2(BEATS)
) (
  input  logic              i_ex_gck,
  input  logic              i_ex_rst_n,
  input  logic              i_ex_op_vld,
  output logic              o_ex_op_acp,
  input  logic [2:0]        i_ex_op_fn,
  input  logic              i_ex_op_wr_pc,
  input  logic              i_ex_op_wr_q,
  input  logic              i_ex_pred_true,
  input  logic              i_ex_stall,
  input  logic [LANE_W-1:0] i_ex_lhs,
  input  logic [LANE_W-1:0] i_ex_rhs,
  output logic [LANE_W-1:0] o_ex_res,
  output logic              o_ex_res_vld,
  output logic [CTR_W-1:0]  o_ex_beat,
  output logic              o_ex_busy,
  output logic              o_ex_pred_wr_en,
  output logic              o_ex_pred_wr_data,
  output logic              o_ex_redirect,
  output logic              o_ex_done
);

  typedef enum logic [2:0] {
    FN_ADD = 3'd0,
    FN_SUB = 3'd1,
    FN_AND = 3'd2,
    FN_OR  = 3'd3,
    FN_XOR = 3'd4,
    FN_EQ  = 3'd5,
    FN_LTU = 3'd6,
    FN_LT  = 3'd7
  } fn_e;

  localparam logic [CTR_W-1:0] LAST = CTR_W'(BEATS - 1);

  fn_e              fn_q;
  logic             wr_pc_q;
  logic             wr_q_q;
  logic             busy_q;
  logic             carry_q;
  logic             eq_acc_q;
  logic [CTR_W-1:0] ctr_q;

  logic              last;
  logic              adv;
  logic              accept;
  logic              busy_d;
  logic              inv;
  logic              is_cmp;
  logic              cin;
  logic              cout;
  logic [LANE_W-1:0] rhs_x;
  logic [LANE_W-1:0] sum;
  logic [LANE_W-1:0] res_lane;
  logic              lane_eq;
  logic              eq_now;
  logic              cmp_res;
  logic              lhs_msb;
  logic              rhs_msb;

  assign last   = (ctr_q == LAST);
  assign adv    = busy_q && !i_ex_stall;
  assign accept = i_ex_op_vld && o_ex_op_acp;
  // An op arriving while a redirecting op is in flight is on the wrong path.
  assign busy_d = i_ex_pred_true && !o_ex_redirect;

  assign inv    = fn_q inside {FN_SUB, FN_EQ, FN_LTU, FN_LT};
  assign is_cmp = fn_q inside {FN_EQ, FN_LTU, FN_LT};

  // Subtraction as lhs + ~rhs + 1: the +1 enters as beat-0 carry-in.
  assign rhs_x       = inv ? ~i_ex_rhs : i_ex_rhs;
  assign cin         = (ctr_q == '0) ? inv : carry_q;
  assign {cout, sum} = {1'b0, i_ex_lhs} + {1'b0, rhs_x} + {{LANE_W{1'b0}}, cin};

  assign lane_eq = (i_ex_lhs == i_ex_rhs);
  // Beat 0 starts a fresh equality chain regardless of the stored flag.
  assign eq_now  = ((ctr_q == '0) || eq_acc_q) && lane_eq;
  assign lhs_msb = i_ex_lhs[LANE_W-1];
  assign rhs_msb = i_ex_rhs[LANE_W-1];

  always_comb begin
    res_lane = sum;
    cmp_res  = 1'b0;
    case (fn_q)
      FN_AND:  res_lane = i_ex_lhs & i_ex_rhs;
      FN_OR:   res_lane = i_ex_lhs | i_ex_rhs;
      FN_XOR:  res_lane = i_ex_lhs ^ i_ex_rhs;
      FN_EQ:   cmp_res  = eq_now;
      FN_LTU:  cmp_res  = !cout;
      // Differing signs decide signed order directly; otherwise it is unsigned.
      FN_LT:   cmp_res  = (lhs_msb != rhs_msb) ? lhs_msb : !cout;
      default: res_lane = sum;
    endcase
  end

  assign o_ex_op_acp       = !busy_q || (last && !i_ex_stall);
  assign o_ex_res          = busy_q ? res_lane : '0;
  assign o_ex_res_vld      = adv && !is_cmp;
  assign o_ex_beat         = ctr_q;
  assign o_ex_busy         = busy_q;
  assign o_ex_pred_wr_en   = adv && last && wr_q_q && is_cmp;
  assign o_ex_pred_wr_data = o_ex_pred_wr_en && cmp_res;
  assign o_ex_redirect     = busy_q && wr_pc_q;
  assign o_ex_done         = adv && last;

  always_ff @(posedge i_ex_gck or negedge i_ex_rst_n) begin
    if (!i_ex_rst_n) begin
      busy_q   <= 1'b0;
      ctr_q    <= '0;
      carry_q  <= 1'b0;
      eq_acc_q <= 1'b1;
      fn_q     <= FN_ADD;
      wr_pc_q  <= 1'b0;
      wr_q_q   <= 1'b0;
    end else begin
      if (adv) begin
        ctr_q    <= last ? '0 : ctr_q + CTR_W'(1);
        carry_q  <= last ? 1'b0 : cout;
        eq_acc_q <= last ? 1'b1 : eq_now;
      end
      if (accept) begin
        fn_q    <= fn_e'(i_ex_op_fn);
        wr_pc_q <= i_ex_op_wr_pc;
        wr_q_q  <= i_ex_op_wr_q;
        busy_q  <= busy_d;
      end else if (adv && last) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_idli_ex_serial_m.sv
// tb/tb_idli_ex_serial_m.sv - directed self-checking bench for idli_ex_serial_m

module tb_idli_ex_serial_m;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 16-bit instance
  logic       rst16, vld16, acp16, wrpc16, wrq16, pt16, st16;
  logic [2:0] fn16;
  logic [3:0] lhs16, rhs16, res16;
  logic       rv16, busy16, pwe16, pwd16, redir16, done16;
  logic [1:0] beat16;

  // 32-bit instance
  logic       rst32, vld32, acp32, wrpc32, wrq32, pt32, st32;
  logic [2:0] fn32;
  logic [3:0] lhs32, rhs32, res32;
  logic       rv32, busy32, pwe32, pwd32, redir32, done32;
  logic [2:0] beat32;

  idli_ex_serial_m #(.WORD_W(16), .LANE_W(4)) dut16 (
    .i_ex_gck(clk), .i_ex_rst_n(rst16), .i_ex_op_vld(vld16), .o_ex_op_acp(acp16),
    .i_ex_op_fn(fn16), .i_ex_op_wr_pc(wrpc16), .i_ex_op_wr_q(wrq16),
    .i_ex_pred_true(pt16), .i_ex_stall(st16), .i_ex_lhs(lhs16), .i_ex_rhs(rhs16),
    .o_ex_res(res16), .o_ex_res_vld(rv16), .o_ex_beat(beat16), .o_ex_busy(busy16),
    .o_ex_pred_wr_en(pwe16), .o_ex_pred_wr_data(pwd16), .o_ex_redirect(redir16),
    .o_ex_done(done16)
  );

  idli_ex_serial_m #(.WORD_W(32), .LANE_W(4)) dut32 (
    .i_ex_gck(clk), .i_ex_rst_n(rst32), .i_ex_op_vld(vld32), .o_ex_op_acp(acp32),
    .i_ex_op_fn(fn32), .i_ex_op_wr_pc(wrpc32), .i_ex_op_wr_q(wrq32),
    .i_ex_pred_true(pt32), .i_ex_stall(st32), .i_ex_lhs(lhs32), .i_ex_rhs(rhs32),
    .o_ex_res(res32), .o_ex_res_vld(rv32), .o_ex_beat(beat32), .o_ex_busy(busy32),
    .o_ex_pred_wr_en(pwe32), .o_ex_pred_wr_data(pwd32), .o_ex_redirect(redir32),
    .o_ex_done(done32)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one op on the 16-bit engine. Inputs change just after the falling
  // edge and outputs are sampled 1 time unit later. With chain set, a new op
  // is presented on the final beat; skip_issue continues such a chained op.
  task automatic op16(input logic [2:0] fn, input logic wrpc, input logic wrq,
                      input logic [15:0] a, input logic [15:0] b,
                      input int st_beat, input int st_len,
                      input logic skip_issue, input logic chain,
                      output logic [15:0] res, output int vcnt,
                      output int pcnt, output logic pdata);
    int k, n, stalled;
    if (!skip_issue) begin
      @(negedge clk);
      vld16 = 1'b1; fn16 = fn; wrpc16 = wrpc; wrq16 = wrq; pt16 = 1'b1;
      #1 chk("acp_idle", acp16, 1);
    end
    k = 0; n = 0; stalled = 0; vcnt = 0; pcnt = 0; res = '0; pdata = 1'b0;
    while (k < 4 && n < 40) begin
      @(negedge clk);
      n++;
      vld16 = 1'b0;
      st16  = (k == st_beat) && (stalled < st_len);
      lhs16 = a[4*k +: 4];
      rhs16 = b[4*k +: 4];
      if (chain && k == 3) begin
        vld16 = 1'b1; wrpc16 = 1'b0; pt16 = 1'b1;
      end
      #1;
      chk("beat", beat16, k);
      chk("busy", busy16, 1);
      chk("redirect", redir16, wrpc);
      chk("acp_beat", acp16, (k == 3) && !st16);
      chk("done", done16, (k == 3) && !st16);
      if (rv16) begin
        res[4*k +: 4] = res16;
        vcnt++;
      end
      if (pwe16) begin
        pcnt++;
        pdata = pwd16;
      end
      if (st16) stalled++;
      else k++;
    end
    chk("beat_bound", (n < 40), 1);
    if (!chain) begin
      @(negedge clk);
      st16 = 1'b0; vld16 = 1'b0;
      #1 chk("idle_after", busy16, 0);
    end
  endtask

  logic [15:0] r;
  int          vc, pc;
  logic        pd;

  initial begin
    rst16 = 1'b0; vld16 = 1'b0; fn16 = 3'd0; wrpc16 = 1'b0; wrq16 = 1'b0;
    pt16 = 1'b1; st16 = 1'b0; lhs16 = '0; rhs16 = '0;
    rst32 = 1'b0; vld32 = 1'b0; fn32 = 3'd0; wrpc32 = 1'b0; wrq32 = 1'b0;
    pt32 = 1'b1; st32 = 1'b0; lhs32 = '0; rhs32 = '0;
    #1;
    chk("rst_acp", acp16, 1);
    chk("rst_busy", busy16, 0);
    chk("rst_res", res16, 0);
    chk("rst_rv", rv16, 0);
    chk("rst_beat", beat16, 0);
    chk("rst_pwe", pwe16, 0);
    chk("rst_pwd", pwd16, 0);
    chk("rst_redir", redir16, 0);
    chk("rst_done", done16, 0);
    repeat (2) @(negedge clk);
    rst16 = 1'b1; rst32 = 1'b1;

    // ADD 0x00FF + 0x0001: lanes 0,0,1,0
    op16(3'd0, 1'b0, 1'b0, 16'h00FF, 16'h0001, -1, 0, 1'b0, 1'b0, r, vc, pc, pd);
    chk("add_res", r, 16'h0100);
    chk("add_vcnt", vc, 4);
    chk("add_pcnt", pc, 0);

    // LTU 0 < 1
    op16(3'd6, 1'b0, 1'b1, 16'h0000, 16'h0001, -1, 0, 1'b0, 1'b0, r, vc, pc, pd);
    chk("ltu_vcnt", vc, 0);
    chk("ltu_pcnt", pc, 1);
    chk("ltu_pd", pd, 1);

    // LT 0x8000 < 0x0001 (signed)
    op16(3'd7, 1'b0, 1'b1, 16'h8000, 16'h0001, -1, 0, 1'b0, 1'b0, r, vc, pc, pd);
    chk("lt_pcnt", pc, 1);
    chk("lt_pd", pd, 1);

    // LT 0x0001 < 0x8000 is false
    op16(3'd7, 1'b0, 1'b1, 16'h0001, 16'h8000, -1, 0, 1'b0, 1'b0, r, vc, pc, pd);
    chk("lt_rev_pd", pd, 0);

    // LTU equal operands -> 0
    op16(3'd6, 1'b0, 1'b1, 16'h1234, 16'h1234, -1, 0, 1'b0, 1'b0, r, vc, pc, pd);
    chk("ltu_eq_pcnt", pc, 1);
    chk("ltu_eq_pd", pd, 0);

    // EQ differing in lowest lane only
    op16(3'd5, 1'b0, 1'b1, 16'h1234, 16'h1235, -1, 0, 1'b0, 1'b0, r, vc, pc, pd);
    chk("eq_ne_pcnt", pc, 1);
    chk("eq_ne_pd", pd, 0);

    op16(3'd5, 1'b0, 1'b1, 16'hABCD, 16'hABCD, -1, 0, 1'b0, 1'b0, r, vc, pc, pd);
    chk("eq_eq_pd", pd, 1);
    chk("eq_eq_vcnt", vc, 0);

    // EQ without wr_q never strobes the predicate
    op16(3'd5, 1'b0, 1'b0, 16'hABCD, 16'hABCD, -1, 0, 1'b0, 1'b0, r, vc, pc, pd);
    chk("eq_nowrq_pcnt", pc, 0);

    // SUB 0x0100 - 0x0001 with beat 1 stalled for 3 cycles
    op16(3'd1, 1'b0, 1'b0, 16'h0100, 16'h0001, 1, 3, 1'b0, 1'b0, r, vc, pc, pd);
    chk("sub_res", r, 16'h00FF);
    chk("sub_vcnt", vc, 4);

    // Logic fns
    op16(3'd2, 1'b0, 1'b0, 16'hF0F0, 16'hFF00, -1, 0, 1'b0, 1'b0, r, vc, pc, pd);
    chk("and_res", r, 16'hF000);
    op16(3'd4, 1'b0, 1'b0, 16'hF0F0, 16'hFF00, -1, 0, 1'b0, 1'b0, r, vc, pc, pd);
    chk("xor_res", r, 16'h0FF0);

    // Back-to-back ADDs: second op's beat 0 directly after first done
    op16(3'd0, 1'b0, 1'b0, 16'h0001, 16'h0002, -1, 0, 1'b0, 1'b1, r, vc, pc, pd);
    chk("b2b_first", r, 16'h0003);
    op16(3'd0, 1'b0, 1'b0, 16'h1234, 16'h1111, -1, 0, 1'b1, 1'b0, r, vc, pc, pd);
    chk("b2b_second", r, 16'h2345);
    chk("b2b_vcnt", vc, 4);

    // Op with false guard predicate is dropped
    @(negedge clk);
    vld16 = 1'b1; fn16 = 3'd0; pt16 = 1'b0; wrpc16 = 1'b0;
    #1 chk("nopred_acp", acp16, 1);
    @(negedge clk);
    vld16 = 1'b0; pt16 = 1'b1;
    #1;
    chk("nopred_busy", busy16, 0);
    chk("nopred_rv", rv16, 0);

    // Op offered on a redirecting op's final beat is squashed
    op16(3'd0, 1'b1, 1'b0, 16'h0000, 16'h0000, -1, 0, 1'b0, 1'b1, r, vc, pc, pd);
    @(negedge clk);
    vld16 = 1'b0;
    #1;
    chk("squash_busy", busy16, 0);
    chk("squash_rv", rv16, 0);
    chk("squash_redir", redir16, 0);

    // 32-bit: reset mid-op at beat 2 of an EQ with predicate write
    @(negedge clk);
    vld32 = 1'b1; fn32 = 3'd5; wrq32 = 1'b1;
    #1 chk("w32_acp", acp32, 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vld32 = 1'b0; lhs32 = 4'h5; rhs32 = 4'h5;
      #1 chk("w32_rst_beat", beat32, k);
    end
    @(negedge clk);
    rst32 = 1'b0;
    #1;
    chk("w32_rst_busy", busy32, 0);
    chk("w32_rst_beat0", beat32, 0);
    chk("w32_rst_pwe", pwe32, 0);
    chk("w32_rst_rv", rv32, 0);
    chk("w32_rst_done", done32, 0);
    @(negedge clk);
    rst32 = 1'b1; wrq32 = 1'b0;

    // 32-bit: ADD 0xFFFFFFFF + 1 -> eight zero lanes
    @(negedge clk);
    vld32 = 1'b1; fn32 = 3'd0;
    #1 chk("w32_add_acp", acp32, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      vld32 = 1'b0; lhs32 = 4'hF; rhs32 = (k == 0) ? 4'h1 : 4'h0;
      #1;
      chk("w32_beat", beat32, k);
      chk("w32_res", res32, 0);
      chk("w32_rv", rv32, 1);
      chk("w32_done", done32, (k == 7));
    end
    @(negedge clk);
    #1 chk("w32_idle", busy32, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
